hazard_monitor: RTL and testbench
=================================

// Module: hazard_monitor
// PURPOSE
//  Downstream of the object controller. Each scan snapshots dino_pos/dino_behavior and the three danger slots, tests bounding boxes one slot per cycle, and drives isColision back to the object controller.
//  Also keeps the run score and high score (4-digit packed BCD) for the display path.
// PARAMETERS
//  DINO_X 40 dino left x; DINO_W 40 dino width; DINO_H_STAND 43 / DINO_H_SIT 26 dino heights
//  GROUND_Y 380 dino top y when grounded and standing; GROUND_LINE 423 cactus bottom y (exclusive)
//  LOW_BIRD_Y 381 / HIGH_BIRD_Y 350 bird top y; SCORE_DIV 8 game_clk ticks per score point
// PORTS
//  game_clk       in  1   game tick clock (all logic)
//  rst            in  1   async, active-high
//  game_state     in  2   0 INIT,1 START,2 END,3 RESET
//  dino_pos       in  10  dino top y, standing reference (screen y grows downward)
//  dino_behavior  in  1   0 SIT, 1 STAND
//  danger_posN    in  10  N=1..3, danger right edge x (exclusive)
//  danger_typeN   in  3   0 LOW_BIRD,1 HIGH_BIRD,2 SMALL,3 MANY,4 BIG,5 NOTHING
//  danger_enN     in  1   slot valid
//  isColision     out 1   sticky collision flag
//  score_bcd      out 16  current score, packed BCD
//  hi_score_bcd   out 16  best score, packed BCD
//  scan_busy      out 1   high while FSM is not in S_IDLE
// BEHAVIOUR
//  Reset: isColision=0, score_bcd=0, hi_score_bcd=0, scan_busy=0, FSM=S_IDLE, tick_cnt=0.
//  FSM: S_IDLE -> S_CHK1 -> S_CHK2 -> S_CHK3 -> S_EVAL -> S_IDLE.
//   S_IDLE: if game_state==START, latch all inputs and clear hit_acc, then go to S_CHK1; otherwise stay.
//   S_CHKn: hit_acc |= overlap(slot n) on the snapshot. S_EVAL: if hit_acc, set isColision=1.
//   Latency: snapshot at edge k -> isColision visible after edge k+4. Scan period is 5 edges.
//  Geometry uses 11-bit unsigned arithmetic throughout.
//   Dino box: x [DINO_X, DINO_X+DINO_W-1].
//   Dino y, STAND: [dino_pos, dino_pos+DINO_H_STAND-1].
//   Dino y, SIT: [dino_pos+DINO_H_STAND-DINO_H_SIT, dino_pos+DINO_H_STAND-1].
//   Danger x: [max(pos-W,0), pos-1]. If pos==0 the slot never overlaps.
//   Cactus y: [GROUND_LINE-H, GROUND_LINE-1]. Bird y: [BIRD_Y, BIRD_Y+BIRD_H-1].
//   W/H table: BIG 27x50, SMALL 19x36, MANY 77x49, birds 47x42. NOTHING or en=0 never overlaps.
//   Overlap = closed-interval intersection on both axes (ax0<=bx1 && bx0<=ax1).
//  isColision is sticky:
//   - Held through END and INIT.
//   - Cleared only in a RESET cycle, or in START before any hit.
//  game_state==RESET, in the same cycle:
//   - isColision=0, score=0, tick_cnt=0, FSM -> S_IDLE (any scan in flight is aborted).
//   - RESET wins over a simultaneous S_EVAL hit.
//  game_state==END or INIT mid-scan: FSM completes the scan; S_IDLE does not restart.
//  Score runs only in START while isColision==0.
//   - tick_cnt counts 0..SCORE_DIV-1; the wrap increments score_bcd by 1 with BCD carry.
//   - Saturates at 0x9999.
//  High score: in any END cycle, if score_bcd > hi_score_bcd (binary compare is valid for packed BCD), copy score_bcd to hi_score_bcd. RESET does not clear hi_score_bcd.
// STRUCTURE
//  Shared package dino_game_pkg holds:
//   - game-state codes, danger-type codes, DINO_SIT/STAND
//   - obstacle width/height constants, WINDOW_WIDTH/HEIGHT, GROUND constants.
//  One sub-module: bcd_counter4.
//   - Ports: clk, rst, clr, inc -> q[15:0], saturating at 9999.
//  Overlap logic is a single combinational function muxed by the FSM slot index.
// TESTING
//  1 START, dino_pos=380 STAND, slot1 SMALL en pos=60 (x 41..59) -> isColision=1 four edges after snapshot.
//  2 Same as 1 but dino_pos=300 (y 300..342) -> isColision stays 0 across 10 scans.
//  3 Slot2 HIGH_BIRD pos=70: dino_behavior=SIT (y 397..422) -> no hit; STAND at 380 -> hit.
//  4 Slot3 BIG pos=5 (x 0..4) -> no hit; slot1 MANY en=0 pos=60 -> no hit.
//  5 Hit, then END 2 cycles, then RESET 1 cycle, then START:
//    - isColision=0 in the RESET cycle; score=0; hi_score=pre-END score.
//    - RESET coincident with S_EVAL -> isColision=0.
//  6 SCORE_DIV=8, 80 START ticks -> score_bcd=16'h0010; preload 9999 plus 8 ticks -> stays 16'h9999; async rst mid-scan -> all outputs 0.

Source files
------------

// File: rtl/dino_game_pkg.sv
// rtl/dino_game_pkg.sv - shared dino game codes, geometry constants and obstacle helpers
package dino_game_pkg;

  localparam logic [1:0] GS_INIT  = 2'd0;
  localparam logic [1:0] GS_START = 2'd1;
  localparam logic [1:0] GS_END   = 2'd2;
  localparam logic [1:0] GS_RESET = 2'd3;

  localparam logic [2:0] DT_LOW_BIRD  = 3'd0;
  localparam logic [2:0] DT_HIGH_BIRD = 3'd1;
  localparam logic [2:0] DT_SMALL     = 3'd2;
  localparam logic [2:0] DT_MANY      = 3'd3;
  localparam logic [2:0] DT_BIG       = 3'd4;
  localparam logic [2:0] DT_NOTHING   = 3'd5;

  localparam logic DINO_SIT   = 1'b0;
  localparam logic DINO_STAND = 1'b1;

  localparam logic [10:0] WINDOW_WIDTH  = 11'd640;
  localparam logic [10:0] WINDOW_HEIGHT = 11'd480;

  localparam logic [10:0] DINO_X       = 11'd40;
  localparam logic [10:0] DINO_W       = 11'd40;
  localparam logic [10:0] DINO_X_R     = DINO_X + DINO_W - 11'd1;
  localparam logic [10:0] DINO_H_STAND = 11'd43;
  localparam logic [10:0] DINO_H_SIT   = 11'd26;
  localparam logic [10:0] GROUND_Y     = 11'd380;
  localparam logic [10:0] GROUND_LINE  = 11'd423;
  localparam logic [10:0] LOW_BIRD_Y   = 11'd381;
  localparam logic [10:0] HIGH_BIRD_Y  = 11'd350;

  localparam logic [10:0] BIG_W   = 11'd27;
  localparam logic [10:0] BIG_H   = 11'd50;
  localparam logic [10:0] SMALL_W = 11'd19;
  localparam logic [10:0] SMALL_H = 11'd36;
  localparam logic [10:0] MANY_W  = 11'd77;
  localparam logic [10:0] MANY_H  = 11'd49;
  localparam logic [10:0] BIRD_W  = 11'd47;
  localparam logic [10:0] BIRD_H  = 11'd42;

  localparam int SCORE_DIV = 8;
  localparam int TICK_W    = $clog2(SCORE_DIV);

  typedef struct packed {
    logic [9:0] pos;
    logic [2:0] typ;
    logic       en;
  } danger_slot_t;

  // Width 0 marks a type that never collides (NOTHING and unused codes).
  function automatic logic [10:0] danger_w(input logic [2:0] typ);
    case (typ)
      DT_LOW_BIRD, DT_HIGH_BIRD: return BIRD_W;
      DT_SMALL:                  return SMALL_W;
      DT_MANY:                   return MANY_W;
      DT_BIG:                    return BIG_W;
      default:                   return 11'd0;
    endcase
  endfunction

  function automatic logic [10:0] danger_h(input logic [2:0] typ);
    case (typ)
      DT_LOW_BIRD, DT_HIGH_BIRD: return BIRD_H;
      DT_SMALL:                  return SMALL_H;
      DT_MANY:                   return MANY_H;
      DT_BIG:                    return BIG_H;
      default:                   return 11'd0;
    endcase
  endfunction

  // Birds fly at fixed heights; cacti stand on the ground line.
  function automatic logic [10:0] danger_top(input logic [2:0] typ);
    case (typ)
      DT_LOW_BIRD:  return LOW_BIRD_Y;
      DT_HIGH_BIRD: return HIGH_BIRD_Y;
      default:      return GROUND_LINE - danger_h(typ);
    endcase
  endfunction

endpackage

// File: rtl/bcd_counter4.sv
// rtl/bcd_counter4.sv - four-digit packed BCD counter saturating at 9999
module bcd_counter4 (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] q
);

  logic [15:0] q_q, q_d;
  logic        carry;

  // Ripple a +1 through the digits; a full 9999 holds instead of wrapping.
  always_comb begin
    q_d   = q_q;
    carry = 1'b1;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != 16'h9999)) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (q_q[4*i +: 4] == 4'd9) begin
            q_d[4*i +: 4] = 4'd0;
          end else begin
            q_d[4*i +: 4] = q_q[4*i +: 4] + 4'd1;
            carry         = 1'b0;
          end
        end
      end
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/hazard_monitor.sv
// rtl/hazard_monitor.sv - scanned dino/obstacle collision check plus run and high score
module hazard_monitor
  import dino_game_pkg::*;
(
  input  logic        game_clk,
  input  logic        rst,
  input  logic [1:0]  game_state,
  input  logic [9:0]  dino_pos,
  input  logic        dino_behavior,
  input  logic [9:0]  danger_pos1,
  input  logic [9:0]  danger_pos2,
  input  logic [9:0]  danger_pos3,
  input  logic [2:0]  danger_type1,
  input  logic [2:0]  danger_type2,
  input  logic [2:0]  danger_type3,
  input  logic        danger_en1,
  input  logic        danger_en2,
  input  logic        danger_en3,
  output logic        isColision,
  output logic [15:0] score_bcd,
  output logic [15:0] hi_score_bcd,
  output logic        scan_busy
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CHK1 = 3'd1;
  localparam logic [2:0] S_CHK2 = 3'd2;
  localparam logic [2:0] S_CHK3 = 3'd3;
  localparam logic [2:0] S_EVAL = 3'd4;

  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(SCORE_DIV - 1);

  logic [2:0]        state_q, state_d;
  logic              latch;
  logic [9:0]        dpos_q;
  logic              dbeh_q;
  danger_slot_t      slot1_q, slot2_q, slot3_q, cur_slot;
  logic              hit_acc_q, cur_hit;
  logic              col_q;
  logic [TICK_W-1:0] tick_q;
  logic              scoring, score_inc, game_reset;
  logic [15:0]       score;
  logic [15:0]       hi_q;

  // Closed-interval box test of the dino against one snapshotted slot.
  function automatic logic slot_overlap(input logic [9:0] dpos, input logic dbeh,
                                        input danger_slot_t s);
    logic [10:0] w, h, pos, ox0, ox1, oy0, oy1, dy0, dy1;
    w   = danger_w(s.typ);
    h   = danger_h(s.typ);
    pos = {1'b0, s.pos};
    dy1 = {1'b0, dpos} + DINO_H_STAND - 11'd1;
    dy0 = (dbeh == DINO_STAND) ? {1'b0, dpos}
                               : {1'b0, dpos} + DINO_H_STAND - DINO_H_SIT;
    ox0 = (pos >= w) ? pos - w : 11'd0;
    ox1 = pos - 11'd1;
    oy0 = danger_top(s.typ);
    oy1 = oy0 + h - 11'd1;
    return s.en && (w != 11'd0) && (pos != 11'd0) &&
           (ox0 <= DINO_X_R) && (DINO_X <= ox1) &&
           (oy0 <= dy1) && (dy0 <= oy1);
  endfunction

  assign game_reset = (game_state == GS_RESET);

  // Scan sequencing; RESET aborts any scan, END/INIT only stop new scans from starting.
  always_comb begin
    state_d = state_q;
    latch   = 1'b0;
    case (state_q)
      S_IDLE: if (game_state == GS_START) begin
        latch   = 1'b1;
        state_d = S_CHK1;
      end
      S_CHK1:  state_d = S_CHK2;
      S_CHK2:  state_d = S_CHK3;
      S_CHK3:  state_d = S_EVAL;
      S_EVAL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (game_reset) begin
      state_d = S_IDLE;
      latch   = 1'b0;
    end
  end

  // Select the slot checked in the current CHK state.
  always_comb begin
    case (state_q)
      S_CHK1:  cur_slot = slot1_q;
      S_CHK2:  cur_slot = slot2_q;
      S_CHK3:  cur_slot = slot3_q;
      default: cur_slot = '0;
    endcase
    cur_hit = slot_overlap(dpos_q, dbeh_q, cur_slot);
  end

  // FSM state, input snapshot and hit accumulation.
  always_ff @(posedge game_clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      dpos_q    <= '0;
      dbeh_q    <= 1'b0;
      slot1_q   <= '0;
      slot2_q   <= '0;
      slot3_q   <= '0;
      hit_acc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (latch) begin
        dpos_q    <= dino_pos;
        dbeh_q    <= dino_behavior;
        slot1_q   <= '{pos: danger_pos1, typ: danger_type1, en: danger_en1};
        slot2_q   <= '{pos: danger_pos2, typ: danger_type2, en: danger_en2};
        slot3_q   <= '{pos: danger_pos3, typ: danger_type3, en: danger_en3};
        hit_acc_q <= 1'b0;
      end else if (state_q == S_CHK1 || state_q == S_CHK2 || state_q == S_CHK3) begin
        hit_acc_q <= hit_acc_q | cur_hit;
      end
    end
  end

  // Sticky collision flag; a RESET cycle beats a coincident EVAL hit.
  always_ff @(posedge game_clk or posedge rst) begin
    if (rst)                                 col_q <= 1'b0;
    else if (game_reset)                     col_q <= 1'b0;
    else if (state_q == S_EVAL && hit_acc_q) col_q <= 1'b1;
  end

  assign scoring   = (game_state == GS_START) && !col_q;
  assign score_inc = scoring && (tick_q == TICK_MAX);

  // Score prescaler: one point every SCORE_DIV live START ticks.
  always_ff @(posedge game_clk or posedge rst) begin
    if (rst)             tick_q <= '0;
    else if (game_reset) tick_q <= '0;
    else if (scoring)    tick_q <= score_inc ? '0 : tick_q + 1'b1;
  end

  bcd_counter4 u_score (
    .clk (game_clk),
    .rst (rst),
    .clr (game_reset),
    .inc (score_inc),
    .q   (score)
  );

  // High score captures the run score during END; survives game RESET.
  always_ff @(posedge game_clk or posedge rst) begin
    if (rst)                                   hi_q <= '0;
    else if (game_state == GS_END && score > hi_q) hi_q <= score;
  end

  assign isColision   = col_q;
  assign score_bcd    = score;
  assign hi_score_bcd = hi_q;
  assign scan_busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_hazard_monitor.sv
// tb/tb_hazard_monitor.sv - randomized self-checking bench for hazard_monitor
module tb_hazard_monitor;

  logic        game_clk = 1'b0;
  logic        rst;
  logic [1:0]  game_state;
  logic [9:0]  dino_pos;
  logic        dino_behavior;
  logic [9:0]  danger_pos1, danger_pos2, danger_pos3;
  logic [2:0]  danger_type1, danger_type2, danger_type3;
  logic        danger_en1, danger_en2, danger_en3;
  logic        isColision;
  logic [15:0] score_bcd, hi_score_bcd;
  logic        scan_busy;
  logic        sat_clr, sat_inc;
  logic [15:0] sat_q;

  int checks = 0;
  int errors = 0;

  int m_ticks;
  int m_hi;
  bit m_col;

  localparam logic [1:0] INIT = 2'd0, START = 2'd1, ENDG = 2'd2, RESETG = 2'd3;

  always #5 game_clk = ~game_clk;

  hazard_monitor dut (
    .game_clk      (game_clk),
    .rst           (rst),
    .game_state    (game_state),
    .dino_pos      (dino_pos),
    .dino_behavior (dino_behavior),
    .danger_pos1   (danger_pos1),
    .danger_pos2   (danger_pos2),
    .danger_pos3   (danger_pos3),
    .danger_type1  (danger_type1),
    .danger_type2  (danger_type2),
    .danger_type3  (danger_type3),
    .danger_en1    (danger_en1),
    .danger_en2    (danger_en2),
    .danger_en3    (danger_en3),
    .isColision    (isColision),
    .score_bcd     (score_bcd),
    .hi_score_bcd  (hi_score_bcd),
    .scan_busy     (scan_busy)
  );

  bcd_counter4 u_sat (
    .clk (game_clk),
    .rst (rst),
    .clr (sat_clr),
    .inc (sat_inc),
    .q   (sat_q)
  );

  function automatic logic [15:0] to_bcd(input int v);
    int c;
    c = (v > 9999) ? 9999 : v;
    return {4'(c / 1000), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
  endfunction

  function automatic int m_score();
    return (m_ticks / 8 > 9999) ? 9999 : m_ticks / 8;
  endfunction

  // Rectangle model of one obstacle against the dino, in plain integers.
  function automatic bit model_hit(input int dpos, input bit stand, input int pos,
                                   input int typ, input bit en);
    int w, h, top, left, right, d_top, d_bot;
    if (!en || pos == 0) return 0;
    case (typ)
      0: begin w = 47; h = 42; top = 381; end
      1: begin w = 47; h = 42; top = 350; end
      2: begin w = 19; h = 36; top = 423 - 36; end
      3: begin w = 77; h = 49; top = 423 - 49; end
      4: begin w = 27; h = 50; top = 423 - 50; end
      default: return 0;
    endcase
    left  = (pos - w < 0) ? 0 : pos - w;
    right = pos - 1;
    d_bot = dpos + 42;
    d_top = stand ? dpos : dpos + 43 - 26;
    return !(right < 40 || left > 79 || top + h - 1 < d_top || top > d_bot);
  endfunction

  // One clock edge with the currently driven game_state; updates the model.
  task automatic clk_edge(input bit eval_hit);
    int pre_score;
    @(posedge game_clk);
    pre_score = m_score();
    case (game_state)
      RESETG: begin m_col = 0; m_ticks = 0; end
      START:  if (!m_col) m_ticks++;
      ENDG:   if (pre_score > m_hi) m_hi = pre_score;
      default: ;
    endcase
    if (game_state != RESETG && eval_hit) m_col = 1;
    #1;
  endtask

  task automatic clear_slots();
    danger_en1 = 0; danger_en2 = 0; danger_en3 = 0;
    danger_pos1 = 0; danger_pos2 = 0; danger_pos3 = 0;
    danger_type1 = 3'd5; danger_type2 = 3'd5; danger_type3 = 3'd5;
  endtask

  task automatic load_one(input int dpos, input bit beh, input int slot,
                          input int pos, input int typ, input bit en);
    clear_slots();
    dino_pos = 10'(dpos);
    dino_behavior = beh;
    case (slot)
      1: begin danger_pos1 = 10'(pos); danger_type1 = 3'(typ); danger_en1 = en; end
      2: begin danger_pos2 = 10'(pos); danger_type2 = 3'(typ); danger_en2 = en; end
      default: begin danger_pos3 = 10'(pos); danger_type3 = 3'(typ); danger_en3 = en; end
    endcase
  endtask

  task automatic scramble();
    dino_pos = 10'($urandom_range(0, 1023));
    dino_behavior = 1'($urandom);
    danger_pos1 = 10'($urandom); danger_pos2 = 10'($urandom); danger_pos3 = 10'($urandom);
    danger_type1 = 3'($urandom_range(0, 5)); danger_type2 = 3'($urandom_range(0, 5));
    danger_type3 = 3'($urandom_range(0, 5));
    danger_en1 = 1'($urandom); danger_en2 = 1'($urandom); danger_en3 = 1'($urandom);
  endtask

  // Starts a scan from idle: snapshot edge in START, then four more edges.
  task automatic run_scan(input logic [1:0] gs_mid, input logic [1:0] gs_eval);
    bit hit;
    hit = model_hit(dino_pos, dino_behavior, danger_pos1, danger_type1, danger_en1) |
          model_hit(dino_pos, dino_behavior, danger_pos2, danger_type2, danger_en2) |
          model_hit(dino_pos, dino_behavior, danger_pos3, danger_type3, danger_en3);
    game_state = START;
    clk_edge(0);
    scramble();
    game_state = gs_mid;
    repeat (3) clk_edge(0);
    game_state = gs_eval;
    clk_edge(hit);
  endtask

  task automatic reset_edge();
    game_state = RESETG;
    clk_edge(0);
  endtask

  task automatic test_reset();
    rst = 1'b1; game_state = INIT; sat_clr = 0; sat_inc = 0;
    dino_pos = 0; dino_behavior = 1; clear_slots();
    m_col = 0; m_ticks = 0; m_hi = 0;
    repeat (2) @(posedge game_clk);
    #1;
    checks++; if (isColision !== 1'b0) begin errors++; $display("FAIL reset_col got %b exp 0", isColision); end
    checks++; if (score_bcd !== 16'h0) begin errors++; $display("FAIL reset_score got %h exp 0000", score_bcd); end
    checks++; if (hi_score_bcd !== 16'h0) begin errors++; $display("FAIL reset_hi got %h exp 0000", hi_score_bcd); end
    checks++; if (scan_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", scan_busy); end
    rst = 1'b0;
  endtask

  task automatic test_geometry();
    reset_edge();
    load_one(380, 1, 1, 60, 2, 1);
    game_state = START;
    clk_edge(0);
    checks++; if (scan_busy !== 1'b1) begin errors++; $display("FAIL busy_after_snapshot got %b exp 1", scan_busy); end
    repeat (3) clk_edge(0);
    checks++; if (isColision !== 1'b0) begin errors++; $display("FAIL col_early got %b exp 0", isColision); end
    clk_edge(1);
    checks++; if (isColision !== 1'b1) begin errors++; $display("FAIL small_stand_hit got %b exp 1", isColision); end
    checks++; if (scan_busy !== 1'b0) begin errors++; $display("FAIL busy_after_eval got %b exp 0", scan_busy); end

    reset_edge();
    for (int i = 0; i < 10; i++) begin
      load_one(300, 1, 1, 60, 2, 1);
      run_scan(START, START);
      checks++; if (isColision !== 1'b0) begin errors++; $display("FAIL high_dino_scan%0d got %b exp 0", i, isColision); end
    end

    reset_edge();
    load_one(380, 0, 2, 70, 1, 1);
    run_scan(START, START);
    checks++; if (isColision !== 1'b0) begin errors++; $display("FAIL sit_under_bird got %b exp 0", isColision); end
    load_one(380, 1, 2, 70, 1, 1);
    run_scan(START, START);
    checks++; if (isColision !== 1'b1) begin errors++; $display("FAIL stand_into_bird got %b exp 1", isColision); end

    reset_edge();
    load_one(380, 1, 3, 5, 4, 1);
    run_scan(START, START);
    checks++; if (isColision !== 1'b0) begin errors++; $display("FAIL big_left_edge got %b exp 0", isColision); end
    load_one(380, 1, 1, 60, 3, 0);
    run_scan(START, START);
    checks++; if (isColision !== 1'b0) begin errors++; $display("FAIL disabled_slot got %b exp 0", isColision); end
  endtask

  task automatic test_end_reset();
    reset_edge();
    clear_slots();
    game_state = START;
    repeat (40) clk_edge(0);
    load_one(380, 1, 1, 60, 2, 1);
    run_scan(START, START);
    checks++; if (isColision !== 1'b1) begin errors++; $display("FAIL pre_end_hit got %b exp 1", isColision); end
    game_state = ENDG;
    repeat (2) clk_edge(0);
    checks++; if (isColision !== 1'b1) begin errors++; $display("FAIL end_hold_col got %b exp 1", isColision); end
    checks++; if (hi_score_bcd !== 16'h0005) begin errors++; $display("FAIL end_hi got %h exp 0005", hi_score_bcd); end
    reset_edge();
    checks++; if (isColision !== 1'b0) begin errors++; $display("FAIL reset_clears_col got %b exp 0", isColision); end
    checks++; if (score_bcd !== 16'h0) begin errors++; $display("FAIL reset_clears_score got %h exp 0000", score_bcd); end
    checks++; if (hi_score_bcd !== 16'h0005) begin errors++; $display("FAIL reset_keeps_hi got %h exp 0005", hi_score_bcd); end

    load_one(380, 1, 1, 60, 2, 1);
    run_scan(START, RESETG);
    checks++; if (isColision !== 1'b0) begin errors++; $display("FAIL reset_beats_eval got %b exp 0", isColision); end

    load_one(380, 1, 1, 60, 2, 1);
    run_scan(ENDG, ENDG);
    checks++; if (isColision !== 1'b1) begin errors++; $display("FAIL end_completes_scan got %b exp 1", isColision); end
    repeat (5) begin
      clk_edge(0);
      checks++; if (scan_busy !== 1'b0) begin errors++; $display("FAIL end_no_restart got %b exp 0", scan_busy); end
    end
    checks++; if (hi_score_bcd !== to_bcd(m_hi)) begin errors++; $display("FAIL hi_after_end got %h exp %h", hi_score_bcd, to_bcd(m_hi)); end
  endtask

  task automatic test_random();
    reset_edge();
    for (int i = 0; i < 40; i++) begin
      if (m_col) reset_edge();
      scramble();
      dino_pos = 10'($urandom_range(280, 400));
      danger_pos1 = 10'($urandom_range(0, 150));
      danger_pos2 = 10'($urandom_range(0, 150));
      danger_pos3 = 10'($urandom_range(0, 150));
      run_scan(START, START);
      checks++; if (isColision !== m_col) begin errors++; $display("FAIL rand_col%0d got %b exp %b", i, isColision, m_col); end
      checks++; if (score_bcd !== to_bcd(m_score())) begin errors++; $display("FAIL rand_score%0d got %h exp %h", i, score_bcd, to_bcd(m_score())); end
    end
  endtask

  task automatic test_score();
    reset_edge();
    clear_slots();
    game_state = START;
    repeat (80) clk_edge(0);
    checks++; if (score_bcd !== 16'h0010) begin errors++; $display("FAIL score_80_ticks got %h exp 0010", score_bcd); end
    game_state = ENDG;
    clk_edge(0);
    checks++; if (hi_score_bcd !== to_bcd(m_hi)) begin errors++; $display("FAIL hi_after_score got %h exp %h", hi_score_bcd, to_bcd(m_hi)); end
    reset_edge();
  endtask

  task automatic test_saturate();
    game_state = INIT;
    sat_clr = 1; clk_edge(0); sat_clr = 0;
    checks++; if (sat_q !== 16'h0) begin errors++; $display("FAIL sat_clear got %h exp 0000", sat_q); end
    sat_inc = 1;
    repeat (1234) clk_edge(0);
    checks++; if (sat_q !== to_bcd(1234)) begin errors++; $display("FAIL sat_1234 got %h exp %h", sat_q, to_bcd(1234)); end
    repeat (9999 - 1234) clk_edge(0);
    checks++; if (sat_q !== 16'h9999) begin errors++; $display("FAIL sat_9999 got %h exp 9999", sat_q); end
    repeat (8) clk_edge(0);
    checks++; if (sat_q !== 16'h9999) begin errors++; $display("FAIL sat_hold got %h exp 9999", sat_q); end
    sat_inc = 0;
  endtask

  task automatic test_async_rst();
    load_one(380, 1, 1, 60, 2, 1);
    game_state = START;
    repeat (3) clk_edge(0);
    #2 rst = 1'b1;
    #1;
    checks++; if (isColision !== 1'b0) begin errors++; $display("FAIL arst_col got %b exp 0", isColision); end
    checks++; if (score_bcd !== 16'h0) begin errors++; $display("FAIL arst_score got %h exp 0000", score_bcd); end
    checks++; if (hi_score_bcd !== 16'h0) begin errors++; $display("FAIL arst_hi got %h exp 0000", hi_score_bcd); end
    checks++; if (scan_busy !== 1'b0) begin errors++; $display("FAIL arst_busy got %b exp 0", scan_busy); end
    @(posedge game_clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_geometry();
    test_end_reset();
    test_random();
    test_score();
    test_saturate();
    test_async_rst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
